// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two producers share the register-file write port, loads win by default,
// and an aging counter forces the ALU path through. Optional macro: WB_ZERO_REG_SUPPRESS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic [4:0]        r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [4:0]        r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              force_active
);

  logic [3:0]        wait_cnt;
  logic              force0;
  logic              acc0;
  logic              acc1;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_we;

  assign force0       = (wait_cnt == 4'(MAX_WAIT));
  assign force_active = force0;

  assign r1_ready = !reset && !force0;
  assign r0_ready = !reset && (force0 || !r1_valid);

  // The ready terms are mutually exclusive whenever r1 is valid, so at most one accept occurs.
  assign acc1 = r1_valid && r1_ready;
  assign acc0 = r0_valid && r0_ready && !acc1;

  always_comb begin
    win_addr = r0_addr;
    win_data = r0_data;
    if (acc1) begin
      win_addr = r1_addr;
      win_data = r1_data;
    end
  end

`ifdef WB_ZERO_REG_SUPPRESS_EN
  // Address 31 is the hard-wired zero register: accept the write but never strobe the decoder.
  assign win_we = (win_addr != 5'd31);
`else
  assign win_we = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!r0_valid || acc0) begin
      wait_cnt <= '0;
    end else if (!force0) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (acc0 || acc1) begin
      wr_en   <= win_we;
      wr_addr <= win_addr;
      wr_data <= win_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural arbitration model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W   = 64;
  localparam int MAX_WAIT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              r0_valid, r1_valid;
  logic [4:0]        r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_data, r1_data;
  logic              r0_ready, r1_ready;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              force_active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] dut_rf [32];

`ifdef WB_ZERO_REG_SUPPRESS_EN
  localparam logic ZERO_WE = 1'b0;
`else
  localparam logic ZERO_WE = 1'b1;
`endif

  regfile_wb_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .force_active(force_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: count of consecutive cycles r0 has waited, and the expected write-port value.
  int                m_lost = 0;
  logic              m_en   = 1'b0;
  logic [4:0]        m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;

  initial begin
    logic fz, e_r0, e_r1, w0, w1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      fz   = (m_lost == MAX_WAIT);
      e_r1 = !reset && !fz;
      e_r0 = !reset && (fz || !r1_valid);
      check("cmp_r0_ready", r0_ready, e_r0);
      check("cmp_r1_ready", r1_ready, e_r1);
      check("cmp_force", force_active, fz);
      check("cmp_wr_en", wr_en, m_en);
      check("cmp_wr_addr", wr_addr, m_addr);
      check("cmp_wr_data", wr_data, m_data);
      if (wr_en === 1'b1) dut_rf[wr_addr] = wr_data;
      if (reset) begin
        m_lost = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
        w1 = r1_valid && e_r1;
        w0 = !w1 && r0_valid && e_r0;
        if (r0_valid && !w0) m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : m_lost;
        else                 m_lost = 0;
        if (w1 || w0) begin
          m_addr = w1 ? r1_addr : r0_addr;
          m_data = w1 ? r1_data : r0_data;
          m_en   = (m_addr == 5'd31) ? ZERO_WE : 1'b1;
        end else begin
          m_en = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    reset = 1'b1;
    r0_valid = 1'b1; r0_addr = 5'd4; r0_data = 64'h1;
    r1_valid = 1'b1; r1_addr = 5'd8; r1_data = 64'h2;

    // Reset with both requesters active
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_r0_ready", r0_ready, 1'b0);
      check("rst_r1_ready", r1_ready, 1'b0);
    end
    step();
    reset = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    check("post_rst_wr_en", wr_en, 1'b0);
    check("post_rst_wr_addr", wr_addr, 5'd0);
    check("post_rst_wr_data", wr_data, 64'h0);
    check("post_rst_force", force_active, 1'b0);

    // Single requester
    step();
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 64'h1234;
    #1;
    check("single_r0_ready", r0_ready, 1'b1);
    step();
    r0_valid = 1'b0;
    #1;
    check("single_wr_en", wr_en, 1'b1);
    check("single_wr_addr", wr_addr, 5'd5);
    check("single_wr_data", wr_data, 64'h1234);
    step();
    #1;
    check("single_wr_en_off", wr_en, 1'b0);

    // Collision on address 3
    step();
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 64'hA;
    r1_valid = 1'b1; r1_addr = 5'd3; r1_data = 64'hB;
    #1;
    check("coll_r1_ready", r1_ready, 1'b1);
    check("coll_r0_ready", r0_ready, 1'b0);
    step();
    r1_valid = 1'b0;
    #1;
    check("coll_first_data", wr_data, 64'hB);
    check("coll_r0_ready2", r0_ready, 1'b1);
    step();
    r0_valid = 1'b0;
    #1;
    check("coll_second_data", wr_data, 64'hA);
    check("coll_second_addr", wr_addr, 5'd3);
    step();
    #1;
    check("coll_reg3_final", dut_rf[3], 64'hA);

    // Aging with r1 continuously valid
    step();
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 64'h99;
    r1_valid = 1'b1; r1_addr = 5'd10; r1_data = 64'h100;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("age_force_low", force_active, 1'b0);
      check("age_r0_blocked", r0_ready, 1'b0);
      step();
      r1_addr = 5'(11 + i); r1_data = 64'(257 + i);
      #1;
    end
    check("age_force_high", force_active, 1'b1);
    check("age_r0_ready", r0_ready, 1'b1);
    check("age_r1_ready", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    #1;
    check("age_wr_addr", wr_addr, 5'd9);
    check("age_wr_data", wr_data, 64'h99);
    check("age_force_clear", force_active, 1'b0);
    step();
    r1_valid = 1'b0;
    #1;
    check("age_held_r1", wr_addr, 5'd13);

    // Sustained r1 throughput
    for (int i = 0; i < 4; i++) begin
      step();
      r1_valid = 1'b1; r1_addr = 5'(16 + i); r1_data = 64'(4096 + i);
    end
    step();
    r1_valid = 1'b0;
    #1;
    check("burst_last_addr", wr_addr, 5'd19);

    // Reset mid-stream while r0 is aging
    step();
    r0_valid = 1'b1; r0_addr = 5'd2; r0_data = 64'h22;
    r1_valid = 1'b1; r1_addr = 5'd6; r1_data = 64'h66;
    step();
    r1_addr = 5'd7; r1_data = 64'h77;
    #1;
    check("mid_r1_ready", r1_ready, 1'b1);
    step();
    reset = 1'b1; r1_valid = 1'b0;
    #1;
    check("mid_pending_en", wr_en, 1'b1);
    check("mid_pending_addr", wr_addr, 5'd7);
    check("mid_rst_r0_ready", r0_ready, 1'b0);
    step();
    reset = 1'b0; r1_valid = 1'b1; r1_addr = 5'd8; r1_data = 64'h88;
    #1;
    check("mid_dropped_en", wr_en, 1'b0);
    check("mid_force_cleared", force_active, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      r1_addr = 5'(20 + i); r1_data = 64'(8192 + i);
      #1;
    end
    check("mid_force_again", force_active, 1'b1);
    step();
    r0_valid = 1'b0;
    step();
    r1_valid = 1'b0;

    // Zero register
    step();
    r0_valid = 1'b1; r0_addr = 5'd31; r0_data = 64'hFF;
    #1;
    check("zero_r0_ready", r0_ready, 1'b1);
    step();
    r0_valid = 1'b0;
    #1;
    check("zero_wr_en", wr_en, ZERO_WE);
    check("zero_wr_addr", wr_addr, 5'd31);
    check("zero_wr_data", wr_data, 64'hFF);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers: the ALU result path (requester 0) and the load-data path (requester 1). Each cycle it grants at most one requester, registers the winning address and data, and presents them one cycle later as the write-port controls. `wr_addr` feeds the register file's 5-to-32 write-enable decoder and `wr_en` drives the decoder enable. Arbitration is fixed-priority to loads, with an aging counter that prevents the ALU path from starving.

## Interface
Parameters:
- DATA_W, 64, width of write data.
- MAX_WAIT, 3, consecutive lost cycles after which requester 0 is forced to win (range 1–15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- r0_valid  in  1  ALU write-back request.
- r0_addr  in  5  ALU destination register.
- r0_data  in  DATA_W  ALU result.
- r0_ready  out  1  ALU request accepted this cycle when high with r0_valid.
- r1_valid  in  1  load write-back request.
- r1_addr  in  5  load destination register.
- r1_data  in  DATA_W  load data.
- r1_ready  out  1  load request accepted this cycle when high with r1_valid.
- wr_en  out  1  register-file write enable (to decoder enable).
- wr_addr  out  5  register-file write address (to decoder select).
- wr_data  out  DATA_W  register-file write data.
- force_active  out  1  high while the aging override is in effect.

## Operation
- Accept: a requester is accepted in a cycle where its valid and ready are both high. Requesters hold valid, addr and data stable until accepted.
- `force0` = (wait_cnt == MAX_WAIT); this signal is `force_active`.
- Ready logic is combinational from the registered state and valids:
  - r1_ready = !reset && !force0.
  - r0_ready = !reset && (force0 || !r1_valid).
- At most one acceptance occurs per cycle. r1 wins unless force0 is high.
- wait_cnt, 4 bits:
  - Cleared to 0 on reset, on an r0 acceptance, or when r0_valid is low.
  - Otherwise incremented when r0_valid is high and r0 is not accepted, saturating at MAX_WAIT.
- The two aging states:
  - NORMAL: wait_cnt < MAX_WAIT.
  - FORCE: wait_cnt == MAX_WAIT. FORCE lasts until r0 is accepted or r0 drops valid.
- Output register:
  - On an acceptance, wr_en←1 and wr_addr/wr_data←the winner's addr/data.
  - With no acceptance, wr_en←0 and wr_addr/wr_data hold their previous values.
- Both requesters targeting the same address in one cycle is legal. Only the winner writes; the loser writes on a later cycle, so the later write is the one that persists.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, force_active=0, wait_cnt=0.
- r0_ready and r1_ready are 0 while reset is high.
- Latency: acceptance in cycle N produces wr_en=1 in cycle N+1. The register file captures the write at the end of cycle N+1.
- Throughput: one write per cycle, sustained.
- Worst-case r0 wait with r1 continuously valid: MAX_WAIT lost cycles, then acceptance on the next cycle.
- Reset asserted mid-operation:
  - Any registered-but-pending output is dropped, so wr_en=0 on the following cycle.
  - wait_cnt is cleared.
  - Requests presented during reset are not accepted.
- Reset deasserted: requests may be accepted in the first cycle with reset low.

## Configuration
- Macro: `WB_ZERO_REG_SUPPRESS_EN`.
- Defined: a write to address 31 (the zero register) is still accepted, so ready and aging behave normally, but wr_en stays 0 for that write. wr_addr and wr_data still update.
- Undefined: address 31 is written like any other register, with wr_en=1.

## Test plan
- Reset: assert reset with both valids high → both readys 0 throughout. The cycle after reset is released: wr_en=0, wr_addr=0, wr_data=0, force_active=0.
- Single requester: r0 presents addr 5, data 0x1234 for one cycle with r1 idle → r0_ready=1 that cycle. Next cycle wr_en=1, wr_addr=5, wr_data=0x1234. The cycle after, wr_en=0.
- Collision: both valid, r0→addr 3 data 0xA, r1→addr 3 data 0xB, MAX_WAIT=3 → r1 accepted first (write 0xB), r0 accepted later (write 0xA). Final write to reg 3 is 0xA.
- Aging: r1 valid every cycle, r0 valid from cycle 0 → r0 loses cycles 0–2 and force_active=1 in cycle 3. In cycle 3 r0_ready=1 and r1_ready=0. wr_addr equals r0_addr in cycle 4, and force_active=0 in cycle 4.
- Reset mid-stream: accept r1 (addr 7) in cycle N and assert reset in cycle N+1 → wr_en=0 in cycle N+2, wait_cnt=0.
- Zero register: r0 writes addr 31, data 0xFF, once with the macro defined and once with it undefined → r0_ready=1 in both cases. Next cycle wr_en=0 with the macro defined, wr_en=1 without it.
